// File: rtl/peak_sched.sv
// Two-channel windowed peak detector with a shared valid/ready result slot; result appears 2 cycles after a window's last sample.
// Samples have no back-pressure: a result still pending when its channel closes again is overwritten and flagged as overrun.
module peak_sched #(
  parameter int BUS_WIDTH = 6,
  parameter int CNT_WIDTH = 9
) (
  input  logic                 dclk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] win_len,
  input  logic                 s_valid,
  input  logic                 s_chan,
  input  logic [BUS_WIDTH-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_chan,
  output logic [BUS_WIDTH-1:0] m_peak,
  output logic                 overrun,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state, state_nx;
  logic [CNT_WIDTH-1:0] win_len_q;
  logic [CNT_WIDTH-1:0] cnt       [2];
  logic [BUS_WIDTH-1:0] run       [2];
  logic [BUS_WIDTH-1:0] pend_peak [2];
  logic [BUS_WIDTH-1:0] new_peak  [2];
  logic [1:0]           pend;
  logic [1:0]           hit;
  logic [1:0]           last;
  logic [1:0]           take;
  logic                 rr;
  logic                 sel;
  logic                 load;

  always_comb begin
    sel    = (pend == 2'b11) ? rr : pend[1];
    load   = (!m_valid || m_ready) && (pend != 2'b00);
    take   = {load && sel, load && !sel};
    // A strobe coinciding with enable falling is dropped along with the partial window.
    hit[0] = (state == RUN) && enable && s_valid && !s_chan;
    hit[1] = (state == RUN) && enable && s_valid && s_chan;
    for (int c = 0; c < 2; c++) begin
      new_peak[c] = (s_data > run[c]) ? s_data : run[c];
      last[c]     = hit[c] && (cnt[c] == win_len_q);
    end

    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = RUN;
      RUN:     if (!enable) state_nx = DRAIN;
      DRAIN:   if ((pend == 2'b00) && !m_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      state     <= IDLE;
      win_len_q <= '0;
      pend      <= '0;
      rr        <= 1'b0;
      m_valid   <= 1'b0;
      m_chan    <= 1'b0;
      m_peak    <= '0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        cnt[c]       <= '0;
        run[c]       <= '0;
        pend_peak[c] <= '0;
      end
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      if (state == IDLE && enable)
        win_len_q <= win_len;

      for (int c = 0; c < 2; c++) begin
        if (state == RUN && !enable) begin
          cnt[c] <= '0;
          run[c] <= '0;
        end else if (last[c]) begin
          pend_peak[c] <= new_peak[c];
          run[c]       <= '0;
          cnt[c]       <= '0;
        end else if (hit[c]) begin
          run[c] <= new_peak[c];
          cnt[c] <= cnt[c] + 1'b1;
        end

        if (last[c])
          pend[c] <= 1'b1;
        else if (take[c])
          pend[c] <= 1'b0;

        if (last[c] && pend[c] && !take[c])
          overrun <= 1'b1;
      end

      if (load) begin
        m_valid <= 1'b1;
        m_chan  <= sel;
        m_peak  <= pend_peak[sel];
        if (pend == 2'b11)
          rr <= ~rr;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_peak_sched.sv
// Directed bench for peak_sched: stimulus queues expected results, an independent monitor checks each accepted result.
module tb_peak_sched;
  localparam int BW = 6;
  localparam int CW = 9;

  logic          dclk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [CW-1:0] win_len = '0;
  logic          s_valid = 1'b0;
  logic          s_chan = 1'b0;
  logic [BW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_chan;
  logic [BW-1:0] m_peak;
  logic          overrun;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int exp_chan[$];
  int exp_peak[$];

  peak_sched #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .dclk(dclk), .rst(rst), .enable(enable), .win_len(win_len),
    .s_valid(s_valid), .s_chan(s_chan), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_chan(m_chan), .m_peak(m_peak),
    .overrun(overrun), .busy(busy)
  );

  always #5 dclk = ~dclk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge dclk);
    #1;
  endtask

  task automatic sample(input int ch, input int d);
    s_valid = 1'b1;
    s_chan  = ch[0];
    s_data  = d[BW-1:0];
    tick();
    s_valid = 1'b0;
  endtask

  task automatic expect_res(input int ch, input int pk);
    exp_chan.push_back(ch);
    exp_peak.push_back(pk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_chan.size() != 0; i++) tick();
    tick(2);
    check(name, exp_chan.size(), 0);
  endtask

  // Monitor: a result is consumed on the coming edge when valid and ready are both high now.
  always @(negedge dclk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_chan.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got chan %0d peak %0d, expected none", m_chan, m_peak);
      end else begin
        check("res_chan", m_chan, exp_chan.pop_front());
        check("res_peak", m_peak, exp_peak.pop_front());
      end
    end
  end

  initial begin
    tick(3);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_chan", m_chan, 0);
    check("rst_m_peak", m_peak, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Single left window; result latency two edges after last strobe
    win_len = 3; enable = 1'b1; m_ready = 1'b1;
    tick();
    check("run_busy", busy, 1);
    expect_res(0, 12);
    sample(0, 5); sample(0, 12); sample(0, 7); sample(0, 3);
    check("lat_edge1", m_valid, 0);
    tick();
    check("lat_edge2", m_valid, 1);
    wait_drain("drain_t1");

    // Interleaved, right peak is the final sample
    expect_res(0, 0); expect_res(1, 63);
    for (int i = 0; i < 4; i++) begin
      sample(0, 0);
      sample(1, (i == 3) ? 63 : i + 1);
    end
    wait_drain("drain_t2");

    // Right closes first while consumer stalls
    m_ready = 1'b0;
    expect_res(1, 20); expect_res(0, 9);
    sample(1, 20); sample(1, 5); sample(1, 5); sample(1, 5);
    sample(0, 9); sample(0, 1); sample(0, 1); sample(0, 1);
    tick(3);
    check("stall_valid", m_valid, 1);
    check("stall_chan", m_chan, 1);
    check("stall_peak", m_peak, 20);
    m_ready = 1'b1;
    wait_drain("drain_t3");

    // Round-robin from reset: left first when both pending, then alternate
    rst = 1'b1; win_len = 0; m_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    expect_res(1, 7); expect_res(0, 8); expect_res(1, 9);
    sample(1, 7); sample(0, 8); sample(1, 9);
    m_ready = 1'b1;
    wait_drain("drain_rr1");
    m_ready = 1'b0;
    expect_res(0, 11); expect_res(1, 13); expect_res(0, 12);
    sample(0, 11); sample(0, 12); sample(1, 13);
    m_ready = 1'b1;
    wait_drain("drain_rr2");
    check("no_overrun", overrun, 0);

    // Overrun: second left window overwrites the first while slot is occupied
    m_ready = 1'b0;
    expect_res(1, 5); expect_res(0, 30);
    sample(1, 5); sample(0, 10); sample(0, 30);
    check("overrun_set", overrun, 1);
    m_ready = 1'b1;
    wait_drain("drain_ovr");
    check("overrun_sticky", overrun, 1);

    // Partial window discarded on stop; strobe at the falling edge ignored
    enable = 1'b0;
    tick(3);
    check("idle_busy", busy, 0);
    enable = 1'b1; win_len = 7;
    tick();
    sample(0, 1); sample(0, 2); sample(0, 3);
    enable = 1'b0;
    sample(0, 40);
    check("drain_busy", busy, 1);
    tick();
    check("stop_busy", busy, 0);
    check("stop_valid", m_valid, 0);
    enable = 1'b1; win_len = 0;
    tick();
    expect_res(0, 4); expect_res(0, 50);
    sample(0, 4); sample(0, 50);
    wait_drain("drain_t5");

    // Reset with result in slot, one pending, and partial windows
    enable = 1'b0;
    tick(3);
    enable = 1'b1; win_len = 3;
    tick();
    m_ready = 1'b0;
    sample(0, 60); sample(0, 1); sample(0, 1); sample(0, 1);
    sample(0, 61); sample(0, 1); sample(0, 1); sample(0, 1);
    sample(1, 62); sample(1, 62); sample(0, 63);
    check("pre_rst_valid", m_valid, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_chan", m_chan, 0);
    check("mid_rst_peak", m_peak, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_busy", busy, 0);
    enable = 1'b0; rst = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    m_ready = 1'b1;
    expect_res(0, 5); expect_res(1, 1);
    sample(0, 2); sample(0, 3); sample(0, 4); sample(0, 5);
    sample(1, 1); sample(1, 1); sample(1, 1); sample(1, 1);
    wait_drain("drain_t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/peak_sched.md
# peak_sched

Two-channel peak-window scheduler for the stereo ADC path. It accepts interleaved left/right sample strobes and keeps a running maximum and window counter per channel. Each closed window's peak is buffered per channel, and the two channels share one valid/ready result port under round-robin arbitration. It sits between the ADC deserialiser and the level-meter/display logic, and adds programmable window length, start/stop sequencing and overrun detection.

## Interface
- BUS_WIDTH, 6, sample and peak width (unsigned)
- CNT_WIDTH, 9, width of window-length setting; max window 2^CNT_WIDTH samples per channel
- dclk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  level; high = run, low = stop and drain
- win_len  in  CNT_WIDTH  window length minus one (samples per channel = win_len+1); sampled only on IDLE->RUN
- s_valid  in  1  one-cycle sample strobe; no back-pressure
- s_chan  in  1  0 = left, 1 = right; qualified by s_valid
- s_data  in  BUS_WIDTH  unsigned sample; qualified by s_valid
- m_valid  out  1  result available
- m_ready  in  1  consumer accepts result when m_valid & m_ready
- m_chan  out  1  channel of current result
- m_peak  out  BUS_WIDTH  window peak
- overrun  out  1  sticky; a pending result was overwritten
- busy  out  1  state != IDLE

## Operation
- Reset value of every output is 0. Reset also puts the FSM in IDLE, clears counters, running maxima, pending flags and the round-robin pointer (left first), and sets win_len_q = 0.
- FSM states and transitions:
  - IDLE: enable=1 -> RUN; latch win_len into win_len_q.
  - RUN: enable=0 -> DRAIN.
  - DRAIN: both pending flags clear and m_valid=0 -> IDLE. enable=1 in DRAIN is ignored until IDLE is reached.
- Samples are processed only in RUN; s_valid in IDLE/DRAIN is ignored.
- Per channel c, on s_valid & s_chan==c in RUN:
  - If cnt[c] < win_len_q: run[c] <= max(run[c], s_data); cnt[c] <= cnt[c]+1.
  - If cnt[c] == win_len_q (last sample; it is included): pend_peak[c] <= max(run[c], s_data); pend[c] <= 1; run[c] <= 0; cnt[c] <= 0.
- Entering DRAIN discards partial windows: cnt and run of both channels clear in the transition cycle. Pending and output results are still delivered.
- Output slot is one register (m_valid/m_chan/m_peak). It loads when empty or being accepted this cycle, and at least one pend is set.
  - Only one pend set: that channel is loaded.
  - Both set: the channel indicated by the round-robin pointer is loaded; the pointer then flips to the other channel.
  - Loading clears that channel's pend, unless a new result for the same channel is written that same cycle, in which case pend stays 1 with the new value.
- Overrun: a new result written into pend[c] while pend[c]=1 and pend[c] is not being moved to the output in that cycle. The new value overwrites, and overrun <= 1 until rst.
- Comparisons are unsigned, BUS_WIDTH wide; no saturation needed.

## Timing
- Last window sample strobed at edge E: pend set after E; m_valid high after E+1 if the output slot is free or accepted at E+1.
- Minimum result latency is 2 cycles from the last-sample strobe. m_valid, m_chan and m_peak are held stable until accepted.
- Back-to-back acceptance with m_ready=1 gives one result per cycle.
- enable falling at edge E: state=DRAIN after E; a sample strobed at E is ignored. busy falls the cycle after the last result is accepted.
- rst asserted mid-window or with results pending drops everything at the next edge; overrun clears.

## Test plan
- win_len=3, m_ready=1, L samples 5,12,7,3 -> one result m_chan=0, m_peak=12, m_valid high exactly 2 cycles after the 4th strobe.
- win_len=3, R samples 1,2,3,63 interleaved with L 0,0,0,0 -> results L=0 then R=63; the last sample is included.
- m_ready=0, both channels close windows (L peak 9, R peak 20, R closes first) -> R delivered first, then L after m_ready=1. With both pending from reset, left goes first, then the pointer alternates.
- m_ready=0 across two complete L windows (peaks 10 then 30) -> overrun=1, stays 1 after acceptance; the pending L result delivered is 30.
- win_len=7, drop enable after 3 L samples -> no result for the partial window, busy falls next cycle. Re-enable with win_len=0, L samples 4,50 -> two results, 4 then 50.
- rst pulse mid-window with a pending result -> all outputs 0 next cycle; after re-enable, first window result is uncontaminated by pre-reset samples.
